// File: rtl/prod_accumulator_if.sv
// Stream bundle between the multiplier, the product accumulator and its consumer.
// The master side drives products and accepts sums; the slave side is the accumulator.
interface prod_accumulator_if #(
  parameter int PW = 32,
  parameter int AW = 40
);
  logic [PW-1:0] prod;
  logic          in_valid;
  logic          in_ready;
  logic          clear;
  logic [AW-1:0] sum;
  logic          ovf;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    count;

  modport master (
    output prod, in_valid, clear, out_ready,
    input  in_ready, sum, ovf, out_valid, count
  );

  modport slave (
    input  prod, in_valid, clear, out_ready,
    output in_ready, sum, ovf, out_valid, count
  );
endinterface

// File: rtl/prod_accumulator.sv
// Sums LEN consecutive unsigned products into one saturating frame sum and holds it
// with a sticky overflow flag until the consumer takes it.
module prod_accumulator #(
  parameter int PW  = 32,
  parameter int AW  = 40,
  parameter int LEN = 4
) (
  input logic clk,
  input logic reset,
  prod_accumulator_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LEN_C = 8'(LEN);

  state_t        state, state_d;
  logic [AW-1:0] acc, acc_d;
  logic [7:0]    count, count_d;
  logic          ovf, ovf_d;
  logic [AW:0]   add_full;
  logic          beat_in;
  logic          beat_out;

  // One guard bit above the accumulator exposes the carry that triggers saturation.
  assign add_full = {1'b0, acc} + {{(AW + 1 - PW){1'b0}}, bus.prod};

  assign bus.in_ready  = (state != DONE) && !bus.clear;
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = acc;
  assign bus.ovf       = ovf;
  assign bus.count     = count;

  assign beat_in  = bus.in_valid & bus.in_ready;
  assign beat_out = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      count <= count_d;
      ovf   <= ovf_d;
    end
  end

  // clear outranks everything, including an output beat completing in DONE.
  always_comb begin
    state_d = state;
    acc_d   = acc;
    count_d = count;
    ovf_d   = ovf;
    if (bus.clear) begin
      state_d = IDLE;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (beat_in) begin
            acc_d   = AW'(bus.prod);
            count_d = 8'd1;
            ovf_d   = 1'b0;
            state_d = (LEN_C == 8'd1) ? DONE : ACC;
          end
        end
        ACC: begin
          if (beat_in) begin
            count_d = count + 8'd1;
            if (add_full[AW]) begin
              acc_d = '1;
              ovf_d = 1'b1;
            end else begin
              acc_d = add_full[AW-1:0];
            end
            if (count_d == LEN_C) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (beat_out) begin
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_prod_accumulator.sv
// Bench for prod_accumulator: three instances (wide sum, narrow 33-bit sum, single-product
// frames) driven from one process; expected frame sums are queued and matched on output beats.
module tb_prod_accumulator;
  logic clk;
  logic reset;

  prod_accumulator_if #(.PW(32), .AW(40)) bus_a ();
  prod_accumulator_if #(.PW(32), .AW(33)) bus_b ();
  prod_accumulator_if #(.PW(32), .AW(40)) bus_c ();

  prod_accumulator #(.PW(32), .AW(40), .LEN(4)) u_a (.clk(clk), .reset(reset), .bus(bus_a));
  prod_accumulator #(.PW(32), .AW(33), .LEN(4)) u_b (.clk(clk), .reset(reset), .bus(bus_b));
  prod_accumulator #(.PW(32), .AW(40), .LEN(1)) u_c (.clk(clk), .reset(reset), .bus(bus_c));

  typedef struct packed {
    logic [39:0] sum;
    logic        ovf;
  } exp_t;

  typedef struct {
    int          sel;
    logic [31:0] p0, p1, p2, p3;
    logic [39:0] sum;
    logic        ovf;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  vec_t vecs[10];
  int   checks;
  int   failures;
  int   cyc;
  int   last_out[3];
  int   prev_out[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return bus_a.in_ready;
      1:       return bus_b.in_ready;
      default: return bus_c.in_ready;
    endcase
  endfunction

  function automatic logic [63:0] vld(input int sel);
    case (sel)
      0:       return 64'(bus_a.out_valid);
      1:       return 64'(bus_b.out_valid);
      default: return 64'(bus_c.out_valid);
    endcase
  endfunction

  function automatic logic [63:0] cnt(input int sel);
    case (sel)
      0:       return 64'(bus_a.count);
      1:       return 64'(bus_b.count);
      default: return 64'(bus_c.count);
    endcase
  endfunction

  task automatic drive(input int sel, input logic [31:0] p, input logic v);
    case (sel)
      0:       begin bus_a.prod = p; bus_a.in_valid = v; end
      1:       begin bus_b.prod = p; bus_b.in_valid = v; end
      default: begin bus_c.prod = p; bus_c.in_valid = v; end
    endcase
  endtask

  task automatic push(input int sel, input logic [39:0] s, input logic o);
    exp_t e;
    e.sum = s;
    e.ovf = o;
    case (sel)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  task automatic score(input int sel, input logic [39:0] s, input logic o);
    exp_t e;
    logic found;
    found = 1'b0;
    e     = '0;
    case (sel)
      0:       if (qa.size() > 0) begin e = qa.pop_front(); found = 1'b1; end
      1:       if (qb.size() > 0) begin e = qb.pop_front(); found = 1'b1; end
      default: if (qc.size() > 0) begin e = qc.pop_front(); found = 1'b1; end
    endcase
    prev_out[sel] = last_out[sel];
    last_out[sel] = cyc;
    check_output($sformatf("sb_expected_pending[%0d]", sel), 64'(found), 64'd1);
    if (found) begin
      check_output($sformatf("sb_sum[%0d]", sel), 64'(s), 64'(e.sum));
      check_output($sformatf("sb_ovf[%0d]", sel), 64'(o), 64'(e.ovf));
    end
  endtask

  // Every cycle passes through here, so output beats are observed mid-cycle without a second process.
  task automatic tick();
    @(negedge clk);
    if (!reset) begin
      if (bus_a.out_valid && bus_a.out_ready && !bus_a.clear) score(0, bus_a.sum, bus_a.ovf);
      if (bus_b.out_valid && bus_b.out_ready && !bus_b.clear) score(1, 40'(bus_b.sum), bus_b.ovf);
      if (bus_c.out_valid && bus_c.out_ready && !bus_c.clear) score(2, bus_c.sum, bus_c.ovf);
    end
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic put_beat(input int sel, input logic [31:0] p);
    int n;
    drive(sel, p, 1'b1);
    n = 0;
    while (!rdy(sel) && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check_output("beat_accept_timeout", 64'(rdy(sel)), 64'd1);
    tick();
  endtask

  task automatic apply_stimulus(input int sel, input logic [31:0] p0, input logic [31:0] p1,
                                input logic [31:0] p2, input logic [31:0] p3);
    put_beat(sel, p0);
    put_beat(sel, p1);
    put_beat(sel, p2);
    #1;
    check_output("out_valid_before_last_beat", vld(sel), 64'd0);
    put_beat(sel, p3);
    drive(sel, 32'd0, 1'b0);
    #1;
    check_output("out_valid_after_last_beat", vld(sel), 64'd1);
    check_output("count_at_done", cnt(sel), 64'd4);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    last_out = '{0, 0, 0};
    prev_out = '{0, 0, 0};
    reset    = 1'b1;
    drive(0, 32'd0, 1'b0);
    drive(1, 32'd0, 1'b0);
    drive(2, 32'd0, 1'b0);
    bus_a.clear = 1'b0; bus_b.clear = 1'b0; bus_c.clear = 1'b0;
    bus_a.out_ready = 1'b1; bus_b.out_ready = 1'b1; bus_c.out_ready = 1'b1;

    vecs[0] = '{0, 32'd1, 32'd2, 32'd65535, 32'd16711425, 40'd16776963, 1'b0};
    vecs[1] = '{0, 32'd0, 32'd0, 32'd0, 32'd0, 40'd0, 1'b0};
    vecs[2] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 40'h3_FFFF_FFFC, 1'b0};
    vecs[3] = '{0, 32'd100, 32'd200, 32'd300, 32'd400, 40'd1000, 1'b0};
    vecs[4] = '{0, 32'h80000000, 32'h80000000, 32'd1, 32'd0, 40'h1_0000_0001, 1'b0};
    vecs[5] = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 40'h1_FFFF_FFFF, 1'b1};
    vecs[6] = '{1, 32'd1, 32'd2, 32'd3, 32'd4, 40'd10, 1'b0};
    vecs[7] = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 40'h1_FFFF_FFFF, 1'b0};
    vecs[8] = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd0, 40'h1_FFFF_FFFF, 1'b1};
    vecs[9] = '{1, 32'd7, 32'd0, 32'd0, 32'd9, 40'd16, 1'b0};

    @(posedge clk);
    @(posedge clk);
    #2;
    check_output("reset_count", cnt(0), 64'd0);
    check_output("reset_sum", 64'(bus_a.sum), 64'd0);
    check_output("reset_ovf", 64'(bus_a.ovf), 64'd0);
    check_output("reset_out_valid_a", vld(0), 64'd0);
    check_output("reset_out_valid_b", vld(1), 64'd0);
    check_output("reset_out_valid_c", vld(2), 64'd0);
    reset = 1'b0;
    #1;
    check_output("in_ready_after_reset", 64'(rdy(0)), 64'd1);

    // Table frames, back to back; consecutive frames on one instance must be 5 cycles apart.
    for (int i = 0; i < 10; i++) begin
      push(vecs[i].sel, vecs[i].sum, vecs[i].ovf);
      apply_stimulus(vecs[i].sel, vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3);
      tick();
      if (i > 0 && vecs[i-1].sel == vecs[i].sel)
        check_output("frame_period", 64'(last_out[vecs[i].sel] - prev_out[vecs[i].sel]), 64'd5);
    end

    // Reset in the middle of a frame discards the partial sum.
    put_beat(0, 32'd5);
    put_beat(0, 32'd6);
    drive(0, 32'd0, 1'b0);
    reset = 1'b1;
    #1;
    check_output("midframe_reset_count", cnt(0), 64'd0);
    check_output("midframe_reset_sum", 64'(bus_a.sum), 64'd0);
    check_output("midframe_reset_valid", vld(0), 64'd0);
    tick();
    reset = 1'b0;
    #1;
    check_output("in_ready_after_release", 64'(rdy(0)), 64'd1);
    push(0, 40'd4, 1'b0);
    apply_stimulus(0, 32'd1, 32'd1, 32'd1, 32'd1);
    tick();

    // Output backpressure: sum held, no input taken while DONE.
    bus_a.out_ready = 1'b0;
    push(0, 40'd34, 1'b0);
    apply_stimulus(0, 32'd7, 32'd8, 32'd9, 32'd10);
    drive(0, 32'd999, 1'b1);
    for (int k = 0; k < 10; k++) begin
      #1;
      check_output("hold_valid", vld(0), 64'd1);
      check_output("hold_sum", 64'(bus_a.sum), 64'd34);
      check_output("hold_in_ready", 64'(rdy(0)), 64'd0);
      check_output("hold_count", cnt(0), 64'd4);
      tick();
    end
    drive(0, 32'd0, 1'b0);
    bus_a.out_ready = 1'b1;
    tick();
    #1;
    check_output("release_valid", vld(0), 64'd0);
    check_output("release_in_ready", 64'(rdy(0)), 64'd1);
    check_output("release_count", cnt(0), 64'd0);

    // clear after two beats with a concurrent input beat that must be dropped.
    put_beat(0, 32'd50);
    put_beat(0, 32'd60);
    bus_a.clear = 1'b1;
    drive(0, 32'd12345, 1'b1);
    #1;
    check_output("clear_in_ready", 64'(rdy(0)), 64'd0);
    tick();
    bus_a.clear = 1'b0;
    drive(0, 32'd0, 1'b0);
    #1;
    check_output("clear_count", cnt(0), 64'd0);
    check_output("clear_valid", vld(0), 64'd0);
    push(0, 40'd100, 1'b0);
    apply_stimulus(0, 32'd10, 32'd20, 32'd30, 32'd40);
    tick();

    // clear in DONE with out_ready=1 drops the pending sum.
    apply_stimulus(0, 32'd1, 32'd2, 32'd3, 32'd4);
    bus_a.clear = 1'b1;
    tick();
    bus_a.clear = 1'b0;
    #1;
    check_output("clear_done_valid", vld(0), 64'd0);
    check_output("clear_done_count", cnt(0), 64'd0);
    check_output("clear_done_in_ready", 64'(rdy(0)), 64'd1);
    push(0, 40'd20, 1'b0);
    apply_stimulus(0, 32'd5, 32'd5, 32'd5, 32'd5);
    tick();

    // Single-product frames: 7 then 9, two cycles apart.
    push(2, 40'd7, 1'b0);
    push(2, 40'd9, 1'b0);
    put_beat(2, 32'd7);
    #1;
    check_output("len1_valid", vld(2), 64'd1);
    put_beat(2, 32'd9);
    drive(2, 32'd0, 1'b0);
    tick();
    check_output("len1_period", 64'(last_out[2] - prev_out[2]), 64'd2);

    repeat (3) tick();
    check_output("queue_a_drained", 64'(qa.size()), 64'd0);
    check_output("queue_b_drained", 64'(qb.size()), 64'd0);
    check_output("queue_c_drained", 64'(qc.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
